// File: rtl/adaptive_binarize.sv
// adaptive_binarize
//   Turns the smoothed 8-bit luminance stream into a 1-bit image. The
//   threshold is either a fixed value or the previous frame's mean luminance
//   plus a signed offset. The mean comes from a frame accumulator and a
//   restoring divider. A new threshold is adopted only on a vsync rising
//   edge, so it never changes in the middle of a frame.
//
// Ports
//   clk, rst_n                      pixel clock, async active-low reset
//   per_frame_vsync/href/clken      input sync strobes
//   per_y                           smoothed luminance
//   bin_mode                        0 = adaptive, 1 = fixed threshold
//   fixed_thresh                    threshold used in fixed mode
//   thresh_offset                   signed offset added to the mean
//   post_frame_vsync/href/clken     input sync strobes delayed one clock
//   post_bit                        1 when the pixel is above the threshold
//   cur_thresh                      threshold applied to the current frame
//   thresh_update                   one-clock pulse when a new mean-based
//                                   pending threshold is written
module adaptive_binarize #(
  parameter logic [8:0] IMG_HDISP   = 9'd320,
  parameter logic [7:0] IMG_VDISP   = 8'd240,
  parameter logic [7:0] THRESH_INIT = 8'd128
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       per_frame_vsync,
  input  logic       per_frame_href,
  input  logic       per_frame_clken,
  input  logic [7:0] per_y,
  input  logic       bin_mode,
  input  logic [7:0] fixed_thresh,
  input  logic [7:0] thresh_offset,
  output logic       post_frame_vsync,
  output logic       post_frame_href,
  output logic       post_frame_clken,
  output logic       post_bit,
  output logic [7:0] cur_thresh,
  output logic       thresh_update
);

  localparam int PIX_MAX = int'(IMG_HDISP) * int'(IMG_VDISP);
  localparam int CNT_W   = $clog2(PIX_MAX + 1);
  localparam int SUM_W   = CNT_W + 8;
  localparam int STEP_W  = $clog2(SUM_W);

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_CALC} state_t;

  state_t              state;
  logic [SUM_W-1:0]    sum;
  logic [CNT_W-1:0]    cnt;
  logic [SUM_W-1:0]    quo;
  logic [CNT_W-1:0]    rem;
  logic [CNT_W-1:0]    divisor;
  logic [STEP_W-1:0]   step;
  logic signed [9:0]   calc_val;
  logic [7:0]          thr_pending;
  logic                pend_req;
  logic [SUM_W-1:0]    pend_sum;
  logic [CNT_W-1:0]    pend_cnt;

  // post_frame_vsync doubles as the registered vsync used for edge detection.
  logic frame_start, frame_end, frame_has_pix;
  assign frame_start   = per_frame_vsync & ~post_frame_vsync;
  assign frame_end     = ~per_frame_vsync & post_frame_vsync;
  assign frame_has_pix = (cnt != '0);

  // One restoring-division step: shift the next dividend bit into the
  // remainder and subtract the divisor when it fits.
  logic [CNT_W:0]    trial, trial_sub;
  logic              fits;
  logic [CNT_W-1:0]  rem_nxt;
  logic [SUM_W-1:0]  quo_nxt;
  assign trial     = {rem, quo[SUM_W-1]};
  assign fits      = (trial >= {1'b0, divisor});
  assign trial_sub = trial - {1'b0, divisor};
  assign rem_nxt   = fits ? trial_sub[CNT_W-1:0] : trial[CNT_W-1:0];
  assign quo_nxt   = {quo[SUM_W-2:0], fits};

  // Mean clamped to 8 bits, plus the sign-extended offset in 10-bit signed.
  logic [7:0]        q_clamp;
  logic signed [9:0] mean_s, offset_s, calc_nxt;
  assign q_clamp  = (|quo_nxt[SUM_W-1:8]) ? 8'hFF : quo_nxt[7:0];
  assign mean_s   = {2'b00, q_clamp};
  assign offset_s = {{2{thresh_offset[7]}}, thresh_offset};
  assign calc_nxt = mean_s + offset_s;

  logic [7:0] calc_sat;
  // NOTE: give every always_comb output a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    calc_sat = calc_val[7:0];
    if (calc_val[9])      calc_sat = 8'h00;
    else if (calc_val[8]) calc_sat = 8'hFF;
  end

  // Pixel path and threshold adoption.
  // NOTE: registers use non-blocking assignments so every flop samples the
  // pre-edge value of the others, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      post_frame_vsync <= 1'b0;
      post_frame_href  <= 1'b0;
      post_frame_clken <= 1'b0;
      post_bit         <= 1'b0;
      cur_thresh       <= THRESH_INIT;
    end else begin
      post_frame_vsync <= per_frame_vsync;
      post_frame_href  <= per_frame_href;
      post_frame_clken <= per_frame_clken;
      if (per_frame_clken) post_bit <= (per_y > cur_thresh);
      if (frame_start)     cur_thresh <= bin_mode ? fixed_thresh : thr_pending;
    end
  end

  // Frame accumulator; runs in both modes so the mean is always fresh.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum <= '0;
      cnt <= '0;
    end else if (frame_end) begin
      sum <= '0;
      cnt <= '0;
    end else if (per_frame_clken && per_frame_vsync) begin
      sum <= sum + {{CNT_W{1'b0}}, per_y};
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Mean FSM. A frame end that arrives while busy is parked in a one-entry
  // pending slot (latest frame wins) and started on return to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      quo           <= '0;
      rem           <= '0;
      divisor       <= '0;
      step          <= '0;
      calc_val      <= '0;
      thr_pending   <= THRESH_INIT;
      thresh_update <= 1'b0;
      pend_req      <= 1'b0;
      pend_sum      <= '0;
      pend_cnt      <= '0;
    end else begin
      thresh_update <= 1'b0;

      if (frame_end && frame_has_pix && state != S_IDLE) begin
        pend_req <= 1'b1;
        pend_sum <= sum;
        pend_cnt <= cnt;
      end

      case (state)
        S_IDLE: begin
          if (frame_end && frame_has_pix) begin
            quo      <= sum;
            divisor  <= cnt;
            rem      <= '0;
            step     <= '0;
            pend_req <= 1'b0;
            state    <= S_DIV;
          end else if (pend_req) begin
            quo      <= pend_sum;
            divisor  <= pend_cnt;
            rem      <= '0;
            step     <= '0;
            pend_req <= 1'b0;
            state    <= S_DIV;
          end
        end
        S_DIV: begin
          quo <= quo_nxt;
          rem <= rem_nxt;
          if (step == STEP_W'(SUM_W - 1)) begin
            calc_val <= calc_nxt;
            state    <= S_CALC;
          end else begin
            step <= step + STEP_W'(1);
          end
        end
        S_CALC: begin
          thr_pending   <= calc_sat;
          thresh_update <= 1'b1;
          state         <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adaptive_binarize.sv
module tb_adaptive_binarize;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       per_frame_vsync = 1'b0;
  logic       per_frame_href = 1'b0;
  logic       per_frame_clken = 1'b0;
  logic [7:0] per_y = 8'd0;
  logic       bin_mode = 1'b0;
  logic [7:0] fixed_thresh = 8'd0;
  logic [7:0] thresh_offset = 8'd0;
  logic       post_frame_vsync, post_frame_href, post_frame_clken;
  logic       post_bit, thresh_update;
  logic [7:0] cur_thresh;

  adaptive_binarize dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .per_frame_vsync  (per_frame_vsync),
    .per_frame_href   (per_frame_href),
    .per_frame_clken  (per_frame_clken),
    .per_y            (per_y),
    .bin_mode         (bin_mode),
    .fixed_thresh     (fixed_thresh),
    .thresh_offset    (thresh_offset),
    .post_frame_vsync (post_frame_vsync),
    .post_frame_href  (post_frame_href),
    .post_frame_clken (post_frame_clken),
    .post_bit         (post_bit),
    .cur_thresh       (cur_thresh),
    .thresh_update    (thresh_update)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit mon_en  = 1'b0;
  bit sb[$];          // expected post_bit per driven pixel
  int frame_px[$];    // pixels of the next frame
  logic pv, ph, pc;   // inputs presented at the last rising edge
  bit exp_valid;
  int exp_pend;
  int model_pend = 128;
  int model_cur  = 128;

  function automatic int sat8(input int v);
    return (v < 0) ? 0 : ((v > 255) ? 255 : v);
  endfunction

  // Advance to the next falling edge and check the delayed syncs and any
  // pixel result that emerged.
  task automatic tick();
    bit e;
    pv = per_frame_vsync;
    ph = per_frame_href;
    pc = per_frame_clken;
    @(negedge clk);
    if (mon_en) begin
      n_tests++;
      if ({post_frame_vsync, post_frame_href, post_frame_clken} !== {pv, ph, pc}) begin
        n_fail++;
        $display("FAIL sync_delay: got %b required %b",
                 {post_frame_vsync, post_frame_href, post_frame_clken}, {pv, ph, pc});
      end
      if (post_frame_clken === 1'b1) begin
        n_tests++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL post_bit_extra: got clken with no pixel outstanding");
        end else begin
          e = sb.pop_front();
          if (post_bit !== e) begin
            n_fail++;
            $display("FAIL post_bit: got %b required %b (thresh %0d)", post_bit, e, model_cur);
          end
        end
      end
    end
  endtask

  // Drive one frame of frame_px, w pixels per line. mid_fixed >= 0 changes
  // fixed_thresh partway through the frame.
  task automatic run_frame(input int w, input int mid_fixed);
    int s, c, off;
    s = 0;
    c = 0;
    per_frame_vsync = 1'b1;
    model_cur = bin_mode ? int'(fixed_thresh) : model_pend;
    tick();
    n_tests++;
    if (cur_thresh !== 8'(model_cur)) begin
      n_fail++;
      $display("FAIL frame_start_thresh: got %0d required %0d", cur_thresh, model_cur);
    end
    tick();
    for (int i = 0; i < frame_px.size(); i++) begin
      per_frame_href  = 1'b1;
      per_frame_clken = 1'b1;
      per_y           = 8'(frame_px[i]);
      sb.push_back(frame_px[i] > model_cur);
      s += frame_px[i];
      c++;
      if (i == 1 && mid_fixed >= 0) fixed_thresh = 8'(mid_fixed);
      tick();
      per_frame_clken = 1'b0;
      if (i == 1 && mid_fixed >= 0) begin
        n_tests++;
        if (cur_thresh !== 8'(model_cur)) begin
          n_fail++;
          $display("FAIL mid_frame_thresh: got %0d required %0d", cur_thresh, model_cur);
        end
      end
      if ((i % w) == w - 1) begin
        per_frame_href = 1'b0;
        tick();
        tick();
      end
    end
    per_frame_href  = 1'b0;
    per_frame_clken = 1'b0;
    per_frame_vsync = 1'b0;
    off = int'($signed(thresh_offset));
    exp_valid = (c != 0);
    if (c != 0) exp_pend = sat8(sat8(s / c) + off);
    tick();  // frame-end edge
  endtask

  // After a frame end: expect one pulse 25-26 clocks later, or none at all
  // for an empty frame.
  task automatic wait_update(input string name);
    int k;
    bit seen;
    seen = 1'b0;
    for (k = 1; k <= 40; k++) begin
      tick();
      if (thresh_update === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    n_tests++;
    if (exp_valid) begin
      if (!seen || k < 25 || k > 26) begin
        n_fail++;
        $display("FAIL %s update_latency: got seen=%0d at clk %0d required 25..26", name, seen, k);
      end
      model_pend = exp_pend;
      if (seen) begin
        tick();
        n_tests++;
        if (thresh_update !== 1'b0) begin
          n_fail++;
          $display("FAIL %s update_width: got %b required 0", name, thresh_update);
        end
      end
    end else if (seen) begin
      n_fail++;
      $display("FAIL %s spurious_update: got pulse at clk %0d required none", name, k);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    n_tests++;
    if ({post_frame_vsync, post_frame_href, post_frame_clken, post_bit, thresh_update} !== 5'b0 ||
        cur_thresh !== 8'd128) begin
      n_fail++;
      $display("FAIL reset_state: got outs %b thresh %0d required 00000 thresh 128",
               {post_frame_vsync, post_frame_href, post_frame_clken, post_bit, thresh_update},
               cur_thresh);
    end
    rst_n = 1'b1;
    tick();
    mon_en = 1'b1;
  endtask

  task automatic test_mean_basic();
    thresh_offset = 8'd0;
    frame_px = {100, 100, 100, 100, 100, 100, 100, 100};
    run_frame(4, -1);
    wait_update("mean100");
    frame_px = {100, 101, 99, 100};
    run_frame(4, -1);
    wait_update("mean100b");
  endtask

  task automatic test_offset_negative();
    thresh_offset = 8'hF6;  // -10
    frame_px = {0, 0, 0, 0, 200, 200, 200, 200};
    run_frame(4, -1);
    wait_update("offset_m10");
    thresh_offset = 8'd0;
    frame_px = {91, 90, 92, 89};
    run_frame(4, -1);
    wait_update("offset_check");
  endtask

  task automatic test_saturate();
    thresh_offset = 8'd60;
    frame_px = {220, 220, 220, 220, 220, 220, 220, 220};
    run_frame(4, -1);
    wait_update("sat_high");
    thresh_offset = 8'hEC;  // -20
    frame_px = {0, 5, 10, 5, 0, 10, 5, 5};
    run_frame(4, -1);
    wait_update("sat_low");
    thresh_offset = 8'd0;
    frame_px = {1, 0, 2, 0};
    run_frame(4, -1);
    wait_update("sat_low_check");
  endtask

  task automatic test_empty_frame();
    frame_px = {};
    run_frame(4, -1);
    wait_update("empty");
    frame_px = {3, 0};
    run_frame(2, -1);
    wait_update("after_empty");
  endtask

  task automatic test_fixed_mode();
    bin_mode     = 1'b1;
    fixed_thresh = 8'd50;
    frame_px = {60, 60, 40, 80};
    run_frame(4, 70);
    wait_update("fixed50");
    frame_px = {71, 70, 69, 200};
    run_frame(4, -1);
    wait_update("fixed70");
    bin_mode = 1'b0;
  endtask

  task automatic test_reset_mid_div();
    frame_px = {10, 10, 10, 10, 10, 10, 10, 10};
    run_frame(4, -1);
    repeat (10) tick();
    mon_en = 1'b0;
    rst_n  = 1'b0;
    tick();
    n_tests++;
    if ({post_frame_vsync, post_frame_href, post_frame_clken, post_bit, thresh_update} !== 5'b0 ||
        cur_thresh !== 8'd128) begin
      n_fail++;
      $display("FAIL reset_mid_div: got outs %b thresh %0d required 00000 thresh 128",
               {post_frame_vsync, post_frame_href, post_frame_clken, post_bit, thresh_update},
               cur_thresh);
    end
    rst_n = 1'b1;
    sb.delete();
    model_pend = 128;
    model_cur  = 128;
    tick();
    tick();
    mon_en    = 1'b1;
    exp_valid = 1'b0;
    wait_update("aborted_div");
    frame_px = {129, 128, 127, 200};
    run_frame(4, -1);
    wait_update("after_reset");
  endtask

  task automatic test_back_to_back();
    int pulses;
    int exp_second;
    frame_px = {40, 40};
    run_frame(2, -1);
    frame_px = {60, 80};
    run_frame(2, -1);   // ends while the first division is still running
    exp_second = exp_pend;
    pulses = 0;
    for (int k = 0; k < 80; k++) begin
      tick();
      if (thresh_update === 1'b1) pulses++;
    end
    n_tests++;
    if (pulses != 2) begin
      n_fail++;
      $display("FAIL back_to_back_pulses: got %0d required 2", pulses);
    end
    model_pend = exp_second;
    frame_px = {71, 70};
    run_frame(2, -1);
    wait_update("after_b2b");
  endtask

  initial begin
    test_reset();
    test_mean_basic();
    test_offset_negative();
    test_saturate();
    test_empty_frame();
    test_fixed_mode();
    test_reset_mid_div();
    test_back_to_back();
    repeat (3) tick();
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d outstanding required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
